sr_flag_sched: RTL

SR_FLAG_SCHED -- requirements
Module: sr_flag_sched

---
 rtl/sr_flag_sched.sv | 146 ++++++++++++++
 1 files changed

// File: rtl/sr_flag_sched.sv
// Round-robin scheduler that drives a bank of SR latch cells (set/reset/enable)
// and keeps a registered shadow copy of their states. Optional macro SR_SCHED_STATUS_EN adds err_o.
module sr_flag_sched #(
    parameter int NREQ     = 4,
    parameter int NFLAG    = 6,
    parameter int IDX_W    = 3,
    parameter int HOLD_CYC = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [NREQ-1:0]       req_i,
    input  logic [NREQ-1:0]       op_i,
    input  logic [NREQ*IDX_W-1:0] idx_i,
    output logic [NREQ-1:0]       gnt_o,
    output logic [NFLAG-1:0]      s_o,
    output logic [NFLAG-1:0]      r_o,
    output logic [NFLAG-1:0]      en_o,
    output logic [NFLAG-1:0]      q_o,
    output logic                  busy_o
`ifdef SR_SCHED_STATUS_EN
    ,
    output logic                  err_o
`endif
);

    localparam int PTR_W = (NREQ > 1) ? $clog2(NREQ) : 1;

    typedef enum logic [1:0] {IDLE, DRIVE, RECOVER} state_t;

    state_t           state;
    logic [PTR_W-1:0] ptr;
    logic [3:0]       hold_cnt;
    logic             cur_op;
    logic [NFLAG-1:0] cur_mask;
`ifdef SR_SCHED_STATUS_EN
    logic             cur_oor;
`endif

    logic             any_req;
    logic [PTR_W-1:0] win;
    logic [PTR_W-1:0] ptr_next;
    logic             win_op;
    logic [IDX_W-1:0] win_idx;
    logic [NFLAG-1:0] win_mask;
    logic             win_oor;

    // First requesting index at or after the pointer, wrapping around.
    always_comb begin
        logic found;
        found = 1'b0;
        win   = ptr;
        for (int unsigned i = 0; i < NREQ; i++) begin
            int unsigned k;
            k = (32'(ptr) + i) % NREQ;
            if (!found && req_i[k]) begin
                found = 1'b1;
                win   = PTR_W'(k);
            end
        end
    end

    assign any_req  = |req_i;
    assign ptr_next = PTR_W'((32'(win) + 1) % NREQ);
    assign win_op   = op_i[win];
    assign win_idx  = idx_i[int'(win)*IDX_W +: IDX_W];
    assign win_oor  = (32'(win_idx) >= NFLAG);

    // An out-of-range index decodes to an empty mask, so nothing is driven or updated.
    always_comb begin
        win_mask = '0;
        for (int unsigned f = 0; f < NFLAG; f++) begin
            win_mask[f] = (32'(win_idx) == f);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            ptr      <= '0;
            hold_cnt <= '0;
            cur_op   <= 1'b0;
            cur_mask <= '0;
            gnt_o    <= '0;
            s_o      <= '0;
            r_o      <= '0;
            en_o     <= '0;
            q_o      <= '0;
            busy_o   <= 1'b0;
`ifdef SR_SCHED_STATUS_EN
            cur_oor  <= 1'b0;
            err_o    <= 1'b0;
`endif
        end else begin
            gnt_o <= '0;
            case (state)
                IDLE: begin
                    if (any_req) begin
                        state      <= DRIVE;
                        busy_o     <= 1'b1;
                        gnt_o[win] <= 1'b1;
                        ptr        <= ptr_next;
                        cur_op     <= win_op;
                        cur_mask   <= win_mask;
                        hold_cnt   <= 4'(HOLD_CYC - 1);
                        en_o       <= win_mask;
                        s_o        <= win_op ? win_mask : '0;
                        r_o        <= win_op ? '0 : win_mask;
`ifdef SR_SCHED_STATUS_EN
                        cur_oor    <= win_oor;
`endif
                    end
                end
                DRIVE: begin
`ifdef SR_SCHED_STATUS_EN
                    if ((|gnt_o) && cur_oor) begin
                        err_o <= 1'b1;
                    end
`endif
                    if (hold_cnt == '0) begin
                        state <= RECOVER;
                        en_o  <= '0;
                        s_o   <= '0;
                        r_o   <= '0;
                        q_o   <= cur_op ? (q_o | cur_mask) : (q_o & ~cur_mask);
                    end else begin
                        hold_cnt <= hold_cnt - 4'd1;
                    end
                end
                RECOVER: begin
                    state  <= IDLE;
                    busy_o <= 1'b0;
                end
                default: begin
                    state  <= IDLE;
                    busy_o <= 1'b0;
                end
            endcase
        end
    end

`ifndef SR_SCHED_STATUS_EN
    logic unused_oor;
    assign unused_oor = win_oor;
`endif

endmodule
